muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, RV32M op request from EX (Funct7 = 0000001, ALUOp = 10).
REQ-004 SHALL have port Funct3, input, 3, op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port SrcA, input, 32, rs1 operand (dividend / multiplicand).
REQ-006 SHALL have port SrcB, input, 32, rs2 operand (divisor / multiplier).
REQ-007 SHALL have port Result, output, 32, registered result; held until the next accepted start.
REQ-008 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse in the cycle Result is first valid.
REQ-010 SHALL have port stall, output, 1, pipeline hold; equals (start AND IDLE) OR state in {PREP, CALC, FIX}.

Function
REQ-011 SHALL implement states IDLE, PREP, CALC, FIX, DONE; DONE -> IDLE unconditionally.
REQ-012 SHALL accept start only in IDLE, latching Funct3, SrcA and SrcB; start in any other state is ignored.
REQ-013 SHALL, on a normal accept, go IDLE -> PREP -> CALC for exactly 32 cycles (counter 0..31) -> FIX -> DONE, so done is high 35 cycles after the accept edge.
REQ-014 SHALL in PREP take operand magnitudes per signedness: MUL/MULH/DIV/REM both signed; MULHSU SrcA signed, SrcB unsigned; MULHU/DIVU/REMU both unsigned; record the result sign.
REQ-015 SHALL multiply by 32-step shift-add into a 64-bit accumulator; FIX negates the 64-bit value if the signs differ; MUL returns bits [31:0], MULH/MULHSU/MULHU return bits [63:32].
REQ-016 SHALL divide by 32-step restoring division using a 33-bit partial remainder; FIX negates the quotient if the operand signs differ and negates the remainder if the dividend was negative.
REQ-017 SHALL treat divide by zero as a special case, going IDLE -> FIX -> DONE (done 2 cycles after accept): DIV/DIVU return 0xFFFFFFFF, REM/REMU return SrcA.
REQ-018 SHALL treat signed overflow (DIV/REM, SrcA = 0x80000000, SrcB = 0xFFFFFFFF) on the same 2-cycle path: DIV returns 0x80000000, REM returns 0x00000000.
REQ-019 SHALL write Result only in FIX; stall is low in DONE so the pipeline captures Result that cycle.
REQ-020 SHALL hold done low in every state except DONE.

Reset
REQ-021 SHALL, while reset is high, force state IDLE, counter 0, accumulators 0, Result 0x00000000, done 0, busy 0, stall 0 at the next edge.
REQ-022 SHALL let reset during any state abort the operation with no done pulse; reset has priority over start.

Structure
REQ-023 SHALL put the state enum, Funct3 op constants, XLEN = 32, CALC_CYCLES = 32 and the special-result constants in the shared package muldiv_pkg.
REQ-024 SHALL split the design into the FSM and counter (this module) plus one sub-module, muldiv_core, which holds the accumulator, remainder and add/sub-shift step logic.

Verification
REQ-025 SHALL check MUL SrcA = 7, SrcB = 0xFFFFFFFD -> Result 0xFFFFFFEB, done exactly 35 cycles after accept, stall low in the done cycle.
REQ-026 SHALL check SrcA = SrcB = 0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
REQ-027 SHALL check SrcA = 0xFFFFFFF9, SrcB = 2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF, DIVU 0x7FFFFFFC, REMU 0x00000001.
REQ-028 SHALL check DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, plus DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, each with done 2 cycles after accept.
REQ-029 SHALL check that start pulsed mid-CALC is ignored (Result from the first op only), and that reset in CALC cycle 10 gives IDLE with Result 0 on the next cycle and no done pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package muldiv_pkg;
  localparam int XLEN        = 32;
  localparam int CALC_CYCLES = 32;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_QUO      = 32'h8000_0000;
  localparam logic [XLEN-1:0] OVF_REM      = 32'h0000_0000;

  function automatic logic op_signed_a(input logic [2:0] op);
    return !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return op_signed_a(op) && (op != OP_MULHSU);
  endfunction
endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - magnitude datapath: shift-add multiply, restoring divide, sign fix-up
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            prep,
  input  logic            calc,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   mdiv;
  logic              neg_q;
  logic              neg_r;

  logic              neg_a;
  logic              neg_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rmd;

  assign neg_a = op_signed_a(op) && a[XLEN-1];
  assign neg_b = op_signed_b(op) && b[XLEN-1];

  // acc low half holds the multiplier / dividend and shifts out as the result bits shift in
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mdiv : '0)};
  assign div_shift = {rem[XLEN-1:0], acc[XLEN-1]};
  assign div_diff  = {rem, acc[XLEN-1]} - {2'b00, mdiv};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      rem   <= '0;
      mdiv  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (prep) begin
      acc   <= {{XLEN{1'b0}}, (neg_a ? (~a + 1'b1) : a)};
      mdiv  <= neg_b ? (~b + 1'b1) : b;
      rem   <= '0;
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
    end else if (calc) begin
      if (op[2]) begin
        if (!div_diff[XLEN+1]) begin
          rem            <= div_diff[XLEN:0];
          acc[XLEN-1:0]  <= {acc[XLEN-2:0], 1'b1};
        end else begin
          rem            <= div_shift;
          acc[XLEN-1:0]  <= {acc[XLEN-2:0], 1'b0};
        end
      end else begin
        acc <= {mul_sum, acc[XLEN-1:1]};
      end
    end
  end

  assign prod = neg_q ? (~acc + 1'b1) : acc;
  assign quo  = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
  assign rmd  = neg_r ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_MUL:                        result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result = quo;
      default:                       result = rmd;
    endcase
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M multiply/divide FSM, step counter and result register
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] Result,
  output logic            busy,
  output logic            done,
  output logic            stall
);
  state_e          state;
  logic [4:0]      cnt;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] core_res;

  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_val;

  // Zero divisor and signed overflow skip the datapath entirely
  assign div_zero    = Funct3[2] && (SrcB == '0);
  assign div_ovf     = (Funct3 == OP_DIV || Funct3 == OP_REM) &&
                       (SrcA == 32'h8000_0000) && (SrcB == 32'hFFFF_FFFF);
  assign special_val = div_zero ? (Funct3[1] ? SrcA : DIV_ZERO_QUO)
                                : (Funct3[1] ? OVF_REM : OVF_QUO);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op          <= '0;
      a           <= '0;
      b           <= '0;
      special     <= 1'b0;
      special_res <= '0;
      Result      <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op  <= Funct3;
            a   <= SrcA;
            b   <= SrcB;
            cnt <= '0;
            if (div_zero || div_ovf) begin
              special     <= 1'b1;
              special_res <= special_val;
              state       <= S_FIX;
            end else begin
              special <= 1'b0;
              state   <= S_PREP;
            end
          end
        end
        S_PREP: state <= S_CALC;
        S_CALC: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'(CALC_CYCLES - 1)) state <= S_FIX;
        end
        S_FIX: begin
          Result <= special ? special_res : core_res;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign stall = (start && state == S_IDLE) ||
                 state == S_PREP || state == S_CALC || state == S_FIX;

  muldiv_core u_core (
    .clk    (clk),
    .reset  (reset),
    .prep   (state == S_PREP),
    .calc   (state == S_CALC),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (core_res)
  );
endmodule
